mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter BLK_BYTES, default 16, iCache block size in bytes; 128-bit block, 4 instructions.
REQ-003 SHALL have port clk, input, 1, single system clock; all state on posedge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mem_din, input, 8, RAM read byte.
REQ-006 SHALL have port mem_dout, output, 8, RAM write byte; registered.
REQ-007 SHALL have port mem_a, output, ADDR_W, RAM byte address; registered.
REQ-008 SHALL have port mem_wr, output, 1, RAM write strobe (1 = write); registered.
REQ-009 SHALL have port ic_req_en, input, 1, iCache miss refill request; held until ic_done.
REQ-010 SHALL have port ic_req_addr, input, ADDR_W, miss address.
REQ-011 SHALL have ports ic_done (output, 1), ic_blk_addr (output, ADDR_W) and ic_blk_data (output, 8*BLK_BYTES): the refill result that drives the cache's fill-enable, fill-address and fill-data inputs.
REQ-012 SHALL have ports ls_req_en (in, 1), ls_wr (in, 1, 1 = store), ls_size (in, 2: 0 byte, 1 half, 2 word), ls_addr (in, ADDR_W), ls_wdata (in, 32); request held until ls_done.
REQ-013 SHALL have ports ls_done (out, 1) and ls_rdata (out, 32, zero-extended load data).
REQ-014 SHALL have port flush, input, 1, misprediction abort.

Function
REQ-015 SHALL implement FSM states IDLE, IFETCH, LOAD and STORE, with byte counter cnt wide enough for BLK_BYTES.
REQ-016 SHALL, in IDLE, give ls_req_en priority over ic_req_en when both are high at the same edge; a request is never preempted once accepted.
REQ-017 SHALL, at accept edge t, latch address, size and wdata, set cnt=0, set mem_a=base, and enter the target state.
REQ-018 SHALL use base = {ic_req_addr[ADDR_W-1:4], 4'b0} for IFETCH and base = ls_addr for LOAD/STORE; N = BLK_BYTES for IFETCH, N = 1<<ls_size otherwise.
REQ-019 SHALL, in reads (IFETCH/LOAD), drive mem_a = base+k after edge t+k for k = 0..N-1, with mem_wr=0; RAM data for byte k is valid one cycle later and is captured at edge t+k+2.
REQ-020 SHALL assemble bytes little-endian: byte k goes to bits [8k+7:8k].
REQ-021 SHALL, after the edge capturing byte N-1 (t+N+1), pulse the done output for exactly one cycle with data valid and return FSM to IDLE; ic_blk_addr = base.
REQ-022 SHALL, in STORE, drive mem_wr=1, mem_a=base+k and mem_dout=wdata[8k+7:8k] after edge t+k, k = 0..N-1, then after edge t+N drive mem_wr=0, pulse ls_done for one cycle and enter IDLE.
REQ-023 SHALL drive mem_wr=0 in every state except STORE's data cycles.
REQ-024 SHALL make a new request acceptable at the edge ending the done cycle; because requesters hold requests only until done, a re-accept of a finished request SHALL NOT occur (requester drops en in the done cycle).
REQ-025 SHALL, on flush during IFETCH or LOAD, go to IDLE at that edge with no done pulse, mem_wr=0, and discard partial data.
REQ-026 SHALL ignore flush during STORE (committed store completes) and in IDLE; flush in IDLE also blocks acceptance at that edge.
REQ-027 SHALL add addresses modulo 2^ADDR_W (wrap at top of memory).
REQ-028 SHALL assert ic_done and ls_done mutually exclusively, never together.

Reset
REQ-029 SHALL, on rst_in high (asynchronous, any state), set FSM=IDLE, cnt=0, mem_a=0, mem_dout=0, mem_wr=0, ic_done=0, ls_done=0, ic_blk_data=0, ic_blk_addr=0, ls_rdata=0.
REQ-030 SHALL, after reset mid-operation, drop the in-flight transfer with no done pulse and no further writes.

Verification
REQ-031 SHALL be covered by: ic_req_addr=0x1234 with RAM[0x1230+k]=k -> mem_a 0x1230..0x123F, ic_done 17 cycles after accept, ic_blk_data=0x0F0E..0100, ic_blk_addr=0x1230.
REQ-032 SHALL be covered by: word load at 0x100, RAM=EF BE AD DE -> ls_done after 5 cycles, ls_rdata=0xDEADBEEF; byte load at 0x103 -> ls_rdata=0x000000DE after 2 cycles.
REQ-033 SHALL be covered by: half store 0xABCD at 0x200 -> two write cycles (0x200=CD, 0x201=AB), ls_done in the third cycle, mem_wr=0 after.
REQ-034 SHALL be covered by: ic_req_en and ls_req_en rising on the same edge -> LOAD served first, IFETCH accepted after ls_done, both complete.
REQ-035 SHALL be covered by: flush at cnt=5 of IFETCH -> IDLE next cycle, no ic_done; flush during STORE -> all bytes written, ls_done issued.
REQ-036 SHALL be covered by: rst_in pulsed asynchronously mid-STORE -> mem_wr=0 immediately, all outputs at reset values, no ls_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM between the iCache refill
// path and the load/store unit.
//
// Ports
//   clk, rst_in            clock, asynchronous active-high reset
//   mem_din                RAM read byte (valid the cycle after mem_a is sampled)
//   mem_dout/mem_a/mem_wr  registered RAM write byte / byte address / write strobe
//   ic_req_en/ic_req_addr  iCache miss refill request, held until ic_done
//   ic_done/ic_blk_addr/ic_blk_data  one-cycle refill result (fill en/addr/data)
//   ls_req_en/ls_wr/ls_size/ls_addr/ls_wdata  load/store request, held until ls_done
//   ls_done/ls_rdata       one-cycle completion, zero-extended load data
//   flush                  misprediction abort (kills IFETCH/LOAD, not STORE)
//
// Reads: mem_a walks base..base+N-1, one byte per cycle; each byte returns
// a cycle later and is captured one edge after that, so the last byte lands
// at the edge that also raises done. Stores: one RAM write per cycle.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int BLK_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  input  logic                   ic_req_en,
  input  logic [ADDR_W-1:0]      ic_req_addr,
  output logic                   ic_done,
  output logic [ADDR_W-1:0]      ic_blk_addr,
  output logic [8*BLK_BYTES-1:0] ic_blk_data,
  input  logic                   ls_req_en,
  input  logic                   ls_wr,
  input  logic [1:0]             ls_size,
  input  logic [ADDR_W-1:0]      ls_addr,
  input  logic [31:0]            ls_wdata,
  output logic                   ls_done,
  output logic [31:0]            ls_rdata,
  input  logic                   flush
);

  localparam int OFF_W = $clog2(BLK_BYTES);
  // cnt runs one past N on reads (issue index leads capture index by one)
  localparam int CNT_W = $clog2(BLK_BYTES + 2);
  localparam int BLK_W = 8 * BLK_BYTES;

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, n_q, n_d, cnt_inc, rd_idx, ls_n;
  logic [ADDR_W-1:0]   base_q, base_d, ic_base;
  logic [31:0]         wdata_q, wdata_d;
  logic [BLK_W-1:0]    buf_q, buf_d;

  logic [7:0]          mem_dout_d;
  logic [ADDR_W-1:0]   mem_a_d, ic_blk_addr_d;
  logic                mem_wr_d, ic_done_d, ls_done_d;
  logic [BLK_W-1:0]    ic_blk_data_d;
  logic [31:0]         ls_rdata_d;

  logic acc_ls, acc_ic;
  logic unused_ic_off;

  // Block offset bits of the miss address are irrelevant to the refill.
  assign unused_ic_off = ^ic_req_addr[OFF_W-1:0];

  assign ic_base = {ic_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign rd_idx  = cnt_q - CNT_W'(1);

  // Size 3 is not a legal encoding; treat it as a word so the transfer
  // never overruns the 32-bit load/store data path.
  always_comb begin
    case (ls_size)
      2'd0:    ls_n = CNT_W'(1);
      2'd1:    ls_n = CNT_W'(2);
      default: ls_n = CNT_W'(4);
    endcase
  end

  // flush in IDLE blocks acceptance on that edge; loads/stores win ties.
  assign acc_ls = (state_q == IDLE) && !flush && ls_req_en;
  assign acc_ic = (state_q == IDLE) && !flush && !ls_req_en && ic_req_en;

  // State register
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc_ls)      state_d = ls_wr ? STORE : LOAD;
        else if (acc_ic) state_d = IFETCH;
      end
      IFETCH, LOAD: begin
        if (flush || cnt_q == n_q) state_d = IDLE;
      end
      STORE: begin
        if (cnt_inc == n_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-values (all outputs are registered below)
  always_comb begin
    cnt_d         = cnt_q;
    n_d           = n_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    buf_d         = buf_q;
    mem_a_d       = mem_a;
    mem_dout_d    = mem_dout;
    mem_wr_d      = 1'b0;
    ic_done_d     = 1'b0;
    ls_done_d     = 1'b0;
    ic_blk_addr_d = ic_blk_addr;
    ic_blk_data_d = ic_blk_data;
    ls_rdata_d    = ls_rdata;
    case (state_q)
      IDLE: begin
        if (acc_ls) begin
          base_d  = ls_addr;
          n_d     = ls_n;
          wdata_d = ls_wdata;
          cnt_d   = '0;
          buf_d   = '0;
          mem_a_d = ls_addr;
          if (ls_wr) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = ls_wdata[7:0];
          end
        end else if (acc_ic) begin
          base_d  = ic_base;
          n_d     = CNT_W'(BLK_BYTES);
          cnt_d   = '0;
          buf_d   = '0;
          mem_a_d = ic_base;
        end
      end
      IFETCH, LOAD: begin
        // On flush nothing is committed; buf is cleared at the next accept.
        if (!flush) begin
          cnt_d = cnt_inc;
          if (cnt_inc < n_q)
            mem_a_d = base_q + ADDR_W'(cnt_inc);
          // byte cnt-1 is on mem_din now (issued two edges ago)
          if (cnt_q != '0) begin
            for (int i = 0; i < BLK_BYTES; i++)
              if (rd_idx == CNT_W'(i)) buf_d[8*i +: 8] = mem_din;
          end
          if (cnt_q == n_q) begin
            if (state_q == IFETCH) begin
              ic_done_d     = 1'b1;
              ic_blk_data_d = buf_d;
              ic_blk_addr_d = base_q;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = buf_d[31:0];
            end
          end
        end
      end
      STORE: begin
        if (cnt_inc == n_q) begin
          ls_done_d = 1'b1;
        end else begin
          cnt_d    = cnt_inc;
          mem_wr_d = 1'b1;
          mem_a_d  = base_q + ADDR_W'(cnt_inc);
          for (int i = 0; i < 4; i++)
            if (cnt_inc == CNT_W'(i)) mem_dout_d = wdata_q[8*i +: 8];
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      mem_a       <= '0;
      mem_dout    <= '0;
      mem_wr      <= 1'b0;
      ic_done     <= 1'b0;
      ls_done     <= 1'b0;
      ic_blk_addr <= '0;
      ic_blk_data <= '0;
      ls_rdata    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a       <= mem_a_d;
      mem_dout    <= mem_dout_d;
      mem_wr      <= mem_wr_d;
      ic_done     <= ic_done_d;
      ls_done     <= ls_done_d;
      ic_blk_addr <= ic_blk_addr_d;
      ic_blk_data <= ic_blk_data_d;
      ls_rdata    <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and a scoreboard of
// expected bus cycles and done pulses.
module tb_mem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int BLK_BYTES = 16;

  logic         clk = 1'b0;
  logic         rst_in = 1'b0;
  logic [7:0]   mem_din;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         ic_req_en = 1'b0;
  logic [31:0]  ic_req_addr = '0;
  logic         ic_done;
  logic [31:0]  ic_blk_addr;
  logic [127:0] ic_blk_data;
  logic         ls_req_en = 1'b0;
  logic         ls_wr = 1'b0;
  logic [1:0]   ls_size = '0;
  logic [31:0]  ls_addr = '0;
  logic [31:0]  ls_wdata = '0;
  logic         ls_done;
  logic [31:0]  ls_rdata;
  logic         flush = 1'b0;

  mem_arbiter #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES)) dut (
    .clk(clk), .rst_in(rst_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .ic_req_en(ic_req_en), .ic_req_addr(ic_req_addr), .ic_done(ic_done),
    .ic_blk_addr(ic_blk_addr), .ic_blk_data(ic_blk_data),
    .ls_req_en(ls_req_en), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .flush(flush)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(logic [15:0] a);
    if (a >= 16'h1230 && a <= 16'h123F) return 8'(a - 16'h1230);
    case (a)
      16'h0100: return 8'hEF;
      16'h0101: return 8'hBE;
      16'h0102: return 8'hAD;
      16'h0103: return 8'hDE;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // RAM: registered read, one-cycle latency; initialised on the first edge.
  logic [7:0] ram   [0:65535];
  logic [7:0] model [0:65535];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(16'(i));
      ram_init <= 1'b1;
    end else begin
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
      mem_din <= ram[mem_a[15:0]];
    end
  end

  typedef struct { int cyc; logic [31:0] addr; logic wr; logic [7:0] data; } bus_t;
  typedef struct { int cyc; logic is_ic; logic chk; logic [127:0] data; logic [31:0] addr; } done_t;
  bus_t  bq[$];
  done_t dq[$];

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare bus activity and done pulses against the scoreboard.
  always @(negedge clk) begin
    if (!rst_in) begin
      bus_t  e;
      done_t d;
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        e = bq.pop_front();
        check("bus_missed_cycle", 128'(cyc), 128'(e.cyc));
      end
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        e = bq.pop_front();
        check("mem_a", mem_a, e.addr);
        check("mem_wr", mem_wr, e.wr);
        if (e.wr) check("mem_dout", mem_dout, e.data);
      end else if (mem_wr) begin
        check("stray_mem_wr", mem_wr, 0);
      end
      if (ic_done || ls_done) begin
        n_done++;
        check("done_exclusive", ic_done & ls_done, 0);
        if (dq.size() == 0) begin
          check("stray_done", {ic_done, ls_done}, 0);
        end else begin
          d = dq.pop_front();
          check("done_cycle", 128'(cyc), 128'(d.cyc));
          check("done_kind", ic_done, d.is_ic);
          if (d.chk && d.is_ic) begin
            check("ic_blk_data", ic_blk_data, d.data);
            check("ic_blk_addr", ic_blk_addr, d.addr);
          end else if (d.chk) begin
            check("ls_rdata", ls_rdata, d.data);
          end
        end
      end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
        d = dq.pop_front();
        check("done_missing", 128'(cyc), 128'(d.cyc));
      end
    end
  end

  function automatic logic [127:0] exp_read(logic [31:0] base, int n);
    logic [127:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = model[16'(base + 32'(k))];
    return r;
  endfunction

  task automatic push_read(bit is_ic, logic [31:0] addr, int n, int t);
    logic [31:0] base = is_ic ? {addr[31:4], 4'h0} : addr;
    for (int k = 0; k < n; k++) bq.push_back('{t + k, base + 32'(k), 1'b0, 8'h00});
    dq.push_back('{t + n + 1, is_ic, 1'b1, exp_read(base, n), base});
  endtask

  task automatic push_store(logic [31:0] addr, int n, logic [31:0] wd, int t);
    for (int k = 0; k < n; k++) begin
      bq.push_back('{t + k, addr + 32'(k), 1'b1, wd[8*k +: 8]});
      model[16'(addr + 32'(k))] = wd[8*k +: 8];
    end
    dq.push_back('{t + n, 1'b0, 1'b0, 128'h0, 32'h0});
  endtask

  // Bounded wait for a done pulse; the requester drops en in the done cycle.
  task automatic wait_done(bit is_ic);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (is_ic ? ic_done : ls_done) got = 1'b1;
    end
    if (is_ic) ic_req_en = 1'b0;
    else       ls_req_en = 1'b0;
    check(is_ic ? "ic_done_seen" : "ls_done_seen", got, 1);
  endtask

  task automatic do_read(bit is_ic, logic [31:0] addr, logic [1:0] size);
    @(negedge clk);
    if (is_ic) begin
      ic_req_en = 1'b1; ic_req_addr = addr;
      push_read(1'b1, addr, BLK_BYTES, cyc + 1);
    end else begin
      ls_req_en = 1'b1; ls_wr = 1'b0; ls_size = size; ls_addr = addr;
      push_read(1'b0, addr, 1 << size, cyc + 1);
    end
    wait_done(is_ic);
  endtask

  task automatic do_store(logic [31:0] addr, logic [1:0] size, logic [31:0] wd);
    @(negedge clk);
    ls_req_en = 1'b1; ls_wr = 1'b1; ls_size = size; ls_addr = addr; ls_wdata = wd;
    push_store(addr, 1 << size, wd, cyc + 1);
    wait_done(1'b0);
    ls_wr = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_ic_done", ic_done, 0);
    check("rst_ls_done", ls_done, 0);
    check("rst_ic_blk_data", ic_blk_data, 0);
    check("rst_ic_blk_addr", ic_blk_addr, 0);
    check("rst_ls_rdata", ls_rdata, 0);
  endtask

  initial begin
    int nd;
    int t;
    for (int i = 0; i < 65536; i++) model[i] = init_byte(16'(i));
    #1 rst_in = 1'b1;
    #1 check_reset_vals();
    @(negedge clk); @(negedge clk);
    #2 rst_in = 1'b0;

    // Block refill: base 0x1230, bytes 0..15, done 17 cycles after accept
    do_read(1'b1, 32'h0000_1234, 2'd0);
    // Word load DEADBEEF, byte load 0xDE
    do_read(1'b0, 32'h0000_0100, 2'd2);
    do_read(1'b0, 32'h0000_0103, 2'd0);
    // Half store then read back
    do_store(32'h0000_0200, 2'd1, 32'h0000_ABCD);
    do_read(1'b0, 32'h0000_0200, 2'd1);

    // Simultaneous requests: load first, refill accepted at the edge ending ls_done
    @(negedge clk);
    ic_req_en = 1'b1; ic_req_addr = 32'h0000_1238;
    ls_req_en = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h0000_0100;
    push_read(1'b0, 32'h0000_0100, 4, cyc + 1);
    wait_done(1'b0);
    push_read(1'b1, 32'h0000_1238, BLK_BYTES, cyc + 1);
    wait_done(1'b1);

    // Flush refill at cnt=5: six addresses issued, no ic_done
    @(negedge clk);
    ic_req_en = 1'b1; ic_req_addr = 32'h0000_2000;
    t = cyc + 1;
    for (int k = 0; k < 6; k++) bq.push_back('{t + k, 32'h0000_2000 + 32'(k), 1'b0, 8'h00});
    nd = n_done;
    repeat (6) @(negedge clk);
    flush = 1'b1; ic_req_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (20) @(negedge clk);
    check("flush_no_ic_done", 128'(n_done), 128'(nd));
    do_read(1'b1, 32'h0000_0057, 2'd0);

    // Flush in IDLE blocks acceptance; flush during STORE is ignored
    @(negedge clk);
    ls_req_en = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
    ls_addr = 32'h0000_0300; ls_wdata = 32'h8765_4321; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_block", mem_wr, 0);
    flush = 1'b0;
    push_store(32'h0000_0300, 4, 32'h8765_4321, cyc + 1);
    @(negedge clk);
    flush = 1'b1;
    wait_done(1'b0);
    flush = 1'b0; ls_wr = 1'b0;
    do_read(1'b0, 32'h0000_0300, 2'd2);

    // Address wrap at top of memory
    do_read(1'b0, 32'hFFFF_FFFE, 2'd2);

    // Reset mid-store: byte 0 reaches RAM, byte 1 is on the bus but never written
    @(negedge clk);
    ls_req_en = 1'b1; ls_wr = 1'b1; ls_size = 2'd2;
    ls_addr = 32'h0000_0400; ls_wdata = 32'h1122_3344;
    t = cyc + 1;
    bq.push_back('{t,     32'h0000_0400, 1'b1, 8'h44});
    bq.push_back('{t + 1, 32'h0000_0401, 1'b1, 8'h33});
    model[16'h0400] = 8'h44;
    nd = n_done;
    @(negedge clk); @(negedge clk);
    #2 rst_in = 1'b1; ls_req_en = 1'b0; ls_wr = 1'b0;
    #1 check_reset_vals();
    #2 rst_in = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_ls_done", 128'(n_done), 128'(nd));
    do_read(1'b0, 32'h0000_0400, 2'd2);

    repeat (3) @(negedge clk);
    check("bus_queue_empty", 128'(bq.size()), 0);
    check("done_queue_empty", 128'(dq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
